// File: rtl/segment_swapchain.sv
// Segment transition controller for one sample-memory read path (modulation or STM).
// Latches a segment-change request and decides on which cycle the active read segment
// changes: immediately for infinite requests, or on a start trigger (index wrap, system
// time, GPIO rising edge) for finite requests, after which completed loops are counted.
//
// Ports:
//   clk_i                clock
//   rst_i                synchronous active-high reset
//   update_settings_i    one-cycle pulse; latches the request fields
//   req_rd_segment_i     requested segment
//   rep_i                loop count, 16'hFFFF = infinite
//   transition_mode_i    8'h00 sync idx, 8'h01 sys time, 8'h02 gpio, 8'hF0 ext
//   transition_value_i   sys time target in [55:0], gpio pin in [1:0]
//   sys_time_i           system time
//   gpio_in_i            synchronised GPIO inputs
//   idx_0_i, idx_1_i     free-running timing index of each segment
//   cycle_0_i, cycle_1_i last index of each segment
//   segment_o            active segment
//   idx_o                read index for the active segment
//   stop_o               finite playback finished
//   busy_o               a transition is pending
module segment_swapchain #(
  parameter int unsigned Depth      = 15,
  parameter int unsigned NumSegment = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             update_settings_i,
  input  logic             req_rd_segment_i,
  input  logic [15:0]      rep_i,
  input  logic [7:0]       transition_mode_i,
  input  logic [63:0]      transition_value_i,
  input  logic [55:0]      sys_time_i,
  input  logic [3:0]       gpio_in_i,
  input  logic [Depth-1:0] idx_0_i,
  input  logic [Depth-1:0] idx_1_i,
  input  logic [Depth-1:0] cycle_0_i,
  input  logic [Depth-1:0] cycle_1_i,
  output logic             segment_o,
  output logic [Depth-1:0] idx_o,
  output logic             stop_o,
  output logic             busy_o
);

  if (NumSegment != 2) begin : gen_bad_num_segment
    $error("segment_swapchain supports exactly two segments");
  end

  localparam logic [7:0]  ModeSysTime = 8'h01;
  localparam logic [7:0]  ModeGpio    = 8'h02;
  localparam logic [7:0]  ModeExt     = 8'hF0;
  localparam logic [15:0] RepInfinite = 16'hFFFF;

  // StSwitch is the one-cycle hop that applies an infinite request without raising busy.
  typedef enum logic [2:0] {StInfinite, StSwitch, StWait, StFinite, StStopped} state_e;

  state_e           state_q, state_d;
  logic             seg_q, seg_d;
  logic [Depth-1:0] idx_q, idx_d;
  logic             stop_q, stop_d;
  logic             busy_q, busy_d;
  logic             req_seg_q, req_seg_d;
  logic [15:0]      rep_q, rep_d;
  logic [7:0]       mode_q, mode_d;
  logic [55:0]      tv_q, tv_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [Depth-1:0] idx0_prev_q, idx1_prev_q;
  logic [3:0]       gpio_prev_q;

  logic       wrap0, wrap1, wrap_req, wrap_act, gpio_rise, trig, loops_done;
  logic [1:0] gpio_pin;
  logic       unused_tv_hi;

  assign unused_tv_hi = ^transition_value_i[63:56];

  assign wrap0     = idx_0_i < idx0_prev_q;
  assign wrap1     = idx_1_i < idx1_prev_q;
  assign wrap_req  = req_seg_q ? wrap1 : wrap0;
  assign wrap_act  = seg_q ? wrap1 : wrap0;
  assign gpio_pin  = tv_q[1:0];
  assign gpio_rise = gpio_in_i[gpio_pin] & ~gpio_prev_q[gpio_pin];
  // 17-bit compare so REP = 16'hFFFE still needs 16'hFFFF loops without overflow.
  assign loops_done = (({1'b0, cnt_q} + 17'd1) == ({1'b0, rep_q} + 17'd1));

  always_comb begin
    case (mode_q)
      ModeSysTime: trig = sys_time_i >= tv_q;
      ModeGpio:    trig = gpio_rise;
      default:     trig = wrap_req;  // sync idx, ext and unknown modes
    endcase
  end

  always_comb begin
    state_d   = state_q;
    seg_d     = seg_q;
    stop_d    = stop_q;
    cnt_d     = cnt_q;
    req_seg_d = req_seg_q;
    rep_d     = rep_q;
    mode_d    = mode_q;
    tv_d      = tv_q;

    case (state_q)
      StSwitch: begin
        seg_d   = req_seg_q;
        stop_d  = 1'b0;
        state_d = StInfinite;
      end
      StWait: begin
        if (trig) begin
          seg_d   = req_seg_q;
          cnt_d   = '0;
          stop_d  = 1'b0;
          state_d = StFinite;
        end
      end
      StFinite: begin
        if (wrap_act) begin
          if (loops_done) begin
            if (mode_q == ModeExt) begin
              seg_d = ~seg_q;
              cnt_d = '0;
            end else begin
              stop_d  = 1'b1;
              state_d = StStopped;
            end
          end else begin
            cnt_d = cnt_q + 16'd1;
          end
        end
      end
      default: ;
    endcase

    // A new request overrides the state but lets a same-cycle completion land first.
    if (update_settings_i) begin
      req_seg_d = req_rd_segment_i;
      rep_d     = rep_i;
      mode_d    = transition_mode_i;
      tv_d      = transition_value_i[55:0];
      state_d   = (rep_i == RepInfinite) ? StSwitch : StWait;
    end

    busy_d = (state_d == StWait);
    if (stop_d) begin
      idx_d = seg_d ? cycle_1_i : cycle_0_i;
    end else begin
      idx_d = seg_d ? idx_1_i : idx_0_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StInfinite;
      seg_q       <= 1'b0;
      idx_q       <= '0;
      stop_q      <= 1'b0;
      busy_q      <= 1'b0;
      req_seg_q   <= 1'b0;
      rep_q       <= '0;
      mode_q      <= '0;
      tv_q        <= '0;
      cnt_q       <= '0;
      idx0_prev_q <= '0;
      idx1_prev_q <= '0;
      gpio_prev_q <= '0;
    end else begin
      state_q     <= state_d;
      seg_q       <= seg_d;
      idx_q       <= idx_d;
      stop_q      <= stop_d;
      busy_q      <= busy_d;
      req_seg_q   <= req_seg_d;
      rep_q       <= rep_d;
      mode_q      <= mode_d;
      tv_q        <= tv_d;
      cnt_q       <= cnt_d;
      idx0_prev_q <= idx_0_i;
      idx1_prev_q <= idx_1_i;
      gpio_prev_q <= gpio_in_i;
    end
  end

  assign segment_o = seg_q;
  assign idx_o     = idx_q;
  assign stop_o    = stop_q;
  assign busy_o    = busy_q;

endmodule
